ws2812_frame_controller: RTL and testbench

Frame sequencer in front of the WS2812 pixel encoder. Holds a host-writable shadow frame of `LENGTH` 24-bit pixels and snapshots it into an active frame on a `show` request. Streams the active pixels, one per handshake, to the single-pixel serial encoder. Then enforces the strip latch (reset-low) interval before the next frame may start.

---
 rtl/ws2812_frame_controller.sv | 135 +++++++++++++
 tb/tb_ws2812_frame_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_controller.sv
// Double-buffered WS2812 frame sequencer: show snapshots shadow->active, streams pixels, then holds the latch gap.
// Pixel 0 offered one cycle after show is sampled in IDLE; pix_valid/pix_data hold stable while pix_ready is low.
module ws2812_frame_controller #(
    parameter int LENGTH       = 2,
    parameter int ADDR_W       = 1,
    parameter int LATCH_CYCLES = 2600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              show,
    output logic              pix_valid,
    output logic [23:0]       pix_data,
    output logic              pix_last,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       shadow_q [LENGTH];
    logic [23:0]       shadow_d [LENGTH];
    logic [23:0]       active_q [LENGTH];
    logic [23:0]       active_d [LENGTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        active_d     = active_q;

        // Address compare per entry, so out-of-range addresses simply match nothing.
        for (int i = 0; i < LENGTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = wr_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Snapshot reads pre-edge shadow, so a same-cycle write lands in the next frame.
                if (show || pending_q) begin
                    active_d  = shadow_q;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (show) begin
                    pending_d = 1'b1;
                end
                if (pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_LATCH;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_LATCH: begin
                if (show) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pix_data = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if ((state_q == S_SEND) && (idx_q == ADDR_W'(i))) begin
                pix_data = active_q[i];
            end
        end
    end

    assign pix_valid  = (state_q == S_SEND);
    assign pix_last   = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_controller.sv
// Directed bench for ws2812_frame_controller with LENGTH=2, LATCH_CYCLES=8.
module tb_ws2812_frame_controller;

    localparam int LENGTH = 2;
    localparam int ADDR_W = 2;
    localparam int LATCH  = 8;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              show;
    logic              pix_valid;
    logic [23:0]       pix_data;
    logic              pix_last;
    logic              pix_ready;
    logic              busy;
    logic              frame_done;

    int compared   = 0;
    int mismatched = 0;

    ws2812_frame_controller #(
        .LENGTH       (LENGTH),
        .ADDR_W       (ADDR_W),
        .LATCH_CYCLES (LATCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .show       (show),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pixel(input string tag, input logic [23:0] d, input logic last);
        chk({tag, "_valid"}, pix_valid, 1);
        chk({tag, "_data"}, pix_data, d);
        chk({tag, "_last"}, pix_last, last);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // Called in the last SEND cycle; returns in the frame_done cycle.
    task automatic latch_phase(input string tag, input bit do_wr,
                               input logic [ADDR_W-1:0] a, input logic [23:0] d);
        for (int k = 0; k < LATCH; k++) begin
            tick();
            if (k == 0 && do_wr) begin
                wr_en   = 1'b1;
                wr_addr = a;
                wr_data = d;
            end else begin
                wr_en = 1'b0;
            end
            chk({tag, "_latch_valid"}, pix_valid, 0);
            chk({tag, "_latch_busy"}, busy, 1);
            chk({tag, "_latch_done"}, frame_done, 0);
        end
        tick();
        wr_en = 1'b0;
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_valid"}, pix_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        show      = 1'b0;
        pix_ready = 1'b1;
        #1;
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame
        wr(0, 24'hABCD00);
        wr(1, 24'h00ABCD);
        chk("idle_busy", busy, 0);
        show = 1'b1;
        tick();
        show = 1'b0;
        pixel("basic_p0", 24'hABCD00, 0);
        tick();
        pixel("basic_p1", 24'h00ABCD, 1);
        latch_phase("basic", 0, 0, 0);
        tick();
        chk("basic_after_done", frame_done, 0);
        chk("basic_after_busy", busy, 0);

        // Backpressure: pix_ready low for the first 5 valid cycles
        show = 1'b1;
        tick();
        show      = 1'b0;
        pix_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pixel("bp_hold", 24'hABCD00, 0);
            tick();
        end
        pix_ready = 1'b1;
        pixel("bp_p0", 24'hABCD00, 0);
        tick();
        pixel("bp_p1", 24'h00ABCD, 1);
        latch_phase("bp", 0, 0, 0);
        tick();

        // Pending show collapses; snapshot taken at pending frame start
        show = 1'b1;
        tick();
        pixel("pend_p0", 24'hABCD00, 0);
        tick();
        pixel("pend_p1", 24'h00ABCD, 1);
        show = 1'b0;
        latch_phase("pend", 1, 0, 24'h123456);
        tick();
        pixel("pend2_p0", 24'h123456, 0);
        tick();
        pixel("pend2_p1", 24'h00ABCD, 1);
        latch_phase("pend2", 0, 0, 0);
        tick();
        chk("pend_once_busy", busy, 0);
        chk("pend_once_valid", pix_valid, 0);
        tick();
        chk("pend_once_busy2", busy, 0);

        // Write collision with show
        show    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 1;
        wr_data = 24'hFFFFFF;
        tick();
        show  = 1'b0;
        wr_en = 1'b0;
        pixel("coll_p0", 24'h123456, 0);
        tick();
        pixel("coll_p1", 24'h00ABCD, 1);
        latch_phase("coll", 0, 0, 0);
        tick();
        show = 1'b1;
        tick();
        show = 1'b0;
        pixel("coll2_p0", 24'h123456, 0);
        tick();
        pixel("coll2_p1", 24'hFFFFFF, 1);
        latch_phase("coll2", 0, 0, 0);

        // Out-of-range write is ignored
        wr(3, 24'h777777);
        show = 1'b1;
        tick();
        show = 1'b0;
        pixel("oor_p0", 24'h123456, 0);
        tick();
        pixel("oor_p1", 24'hFFFFFF, 1);
        latch_phase("oor", 0, 0, 0);
        tick();

        // Reset during LATCH, with a pending show outstanding
        show = 1'b1;
        tick();
        pixel("rstm_p0", 24'h123456, 0);
        tick();
        show = 1'b0;
        tick();
        tick();
        chk("rstm_latch_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_async_valid", pix_valid, 0);
        chk("rstm_async_busy", busy, 0);
        chk("rstm_async_data", pix_data, 0);
        chk("rstm_async_last", pix_last, 0);
        chk("rstm_async_done", frame_done, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstm_idle_busy", busy, 0);
            chk("rstm_idle_valid", pix_valid, 0);
        end
        show = 1'b1;
        tick();
        show = 1'b0;
        pixel("rstm_p0z", 24'h000000, 0);
        tick();
        pixel("rstm_p1z", 24'h000000, 1);
        latch_phase("rstm", 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
